// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and control bundles for the RV32 control pipeline.
// Opcodes, result/imm/alu encodings, stage bundles and the bubble constants.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] RES_ALU   = 3'b000;
  localparam logic [2:0] RES_MEM   = 3'b001;
  localparam logic [2:0] RES_PC4   = 3'b010;
  localparam logic [2:0] RES_IMM   = 3'b011;
  localparam logic [2:0] RES_PCIMM = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_MDU = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       jalr_src;
    logic [2:0] branch_type;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] result_src;
    logic       mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] result_src;
  } mem_wb_t;

  localparam ctrl_t   CTRL_BUBBLE = '0;
  localparam ex_mem_t EM_BUBBLE   = '0;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_st_t;

endpackage

// File: rtl/riscv_ctrl_pipeline_decoder.sv
// Combinational main decoder: instruction word -> control bundle.
// Macro RISCV_CTRL_MEXT_EN makes funct7=0000001 R-type legal (MDU op).
module riscv_main_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic [2:0]  o_imm_src,
  output logic        o_illegal
);

  logic [6:0] w_op;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic       w_unused;

  assign w_op     = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    o_ctrl    = CTRL_BUBBLE;
    o_imm_src = IMM_I;
    o_illegal = 1'b0;
    unique case (w_op)
      OP_R: begin
        if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALU_FN;
        end
`ifdef RISCV_CTRL_MEXT_EN
        else if (w_f7 == 7'b0000001) begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALU_MDU;
        end
`endif
        else begin
          o_illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_MEM;
        o_ctrl.alu_src    = 1'b1;
      end
      OP_IMM: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FN;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_JALR: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.jump       = 1'b1;
        o_ctrl.jalr_src   = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_imm_src        = IMM_S;
      end
      OP_BRANCH: begin
        if (w_f3 == 3'b010 || w_f3 == 3'b011) begin
          o_illegal = 1'b1;
        end else begin
          o_ctrl.branch      = 1'b1;
          o_ctrl.branch_type = w_f3;
          o_ctrl.alu_op      = ALU_SUB;
          o_imm_src          = IMM_B;
        end
      end
      OP_LUI: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_IMM;
        o_imm_src         = IMM_U;
      end
      OP_AUIPC: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_PCIMM;
        o_imm_src         = IMM_U;
      end
      OP_JAL: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.jump       = 1'b1;
        o_imm_src         = IMM_J;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_ctrl_pipeline.sv
// Control path: decode, ID/EX, EX/MEM, MEM/WB registers, illegal counter.
// Macro RISCV_CTRL_MEXT_EN adds the multicycle MDU stall FSM.
module riscv_ctrl_pipeline
  import riscv_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int ILL_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_d,
  input  logic                 stall_d,
  input  logic                 flush_e,
  output logic [2:0]           imm_src_d,
  output logic                 illegal_d,
  output logic                 reg_write_e,
  output logic                 reg_write_m,
  output logic                 reg_write_w,
  output logic [2:0]           result_src_e,
  output logic [2:0]           result_src_m,
  output logic [2:0]           result_src_w,
  output logic                 mem_write_e,
  output logic                 mem_write_m,
  output logic                 jump_e,
  output logic                 branch_e,
  output logic                 jalr_src_e,
  output logic [2:0]           branch_type_e,
  output logic [1:0]           alu_op_e,
  output logic                 alu_src_e,
  output logic                 mdu_stall,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  ctrl_t                w_ctrl_d;
  ctrl_t                r_de;
  ex_mem_t              r_em;
  mem_wb_t              r_mw;
  logic [ILL_CNT_W-1:0] r_ill_cnt;
  logic                 w_mdu_stall;
  logic                 w_kill_e;
  logic                 w_load_d;

  riscv_main_decoder u_dec (
    .i_instr   (instr_d),
    .o_ctrl    (w_ctrl_d),
    .o_imm_src (imm_src_d),
    .o_illegal (illegal_d)
  );

`ifdef RISCV_CTRL_MEXT_EN
  localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

  mdu_st_t       r_st;
  mdu_st_t       w_st_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_mdu_e;

  assign w_mdu_e = (r_de.alu_op == ALU_MDU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= MDU_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_cnt_nxt   = r_cnt;
    w_mdu_stall = 1'b0;
    w_kill_e    = 1'b0;
    unique case (r_st)
      MDU_IDLE: begin
        if (w_mdu_e && MDU_LATENCY > 1) begin
          w_mdu_stall = 1'b1;
          if (!flush_e) begin
            w_st_nxt  = MDU_BUSY;
            w_cnt_nxt = CW'(1);
          end
        end
      end
      MDU_BUSY: begin
        w_mdu_stall = (r_cnt != CW'(MDU_LATENCY - 1));
        if (flush_e) begin
          w_st_nxt  = MDU_IDLE;
          w_cnt_nxt = '0;
          w_kill_e  = 1'b1;
        end else if (!w_mdu_stall) begin
          w_st_nxt  = MDU_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_st_nxt  = MDU_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end
`else
  logic w_unused_lat;
  assign w_unused_lat = (MDU_LATENCY > 0);
  assign w_mdu_stall  = 1'b0;
  assign w_kill_e     = 1'b0;
`endif

  assign w_load_d = !flush_e && !w_mdu_stall && !stall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de      <= CTRL_BUBBLE;
      r_em      <= EM_BUBBLE;
      r_mw      <= '0;
      r_ill_cnt <= '0;
    end else begin
      if (flush_e)          r_de <= CTRL_BUBBLE;
      else if (w_mdu_stall) r_de <= r_de;
      else if (stall_d)     r_de <= CTRL_BUBBLE;
      else                  r_de <= w_ctrl_d;
      // MDU op stays in EX; bubbles go downstream meanwhile
      if (w_mdu_stall || w_kill_e) r_em <= EM_BUBBLE;
      else r_em <= '{r_de.reg_write, r_de.result_src, r_de.mem_write};
      r_mw <= '{r_em.reg_write, r_em.result_src};
      if (w_load_d && illegal_d && r_ill_cnt != '1)
        r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  assign reg_write_e   = r_de.reg_write;
  assign result_src_e  = r_de.result_src;
  assign mem_write_e   = r_de.mem_write;
  assign jump_e        = r_de.jump;
  assign branch_e      = r_de.branch;
  assign jalr_src_e    = r_de.jalr_src;
  assign branch_type_e = r_de.branch_type;
  assign alu_op_e      = r_de.alu_op;
  assign alu_src_e     = r_de.alu_src;
  assign reg_write_m   = r_em.reg_write;
  assign result_src_m  = r_em.result_src;
  assign mem_write_m   = r_em.mem_write;
  assign reg_write_w   = r_mw.reg_write;
  assign result_src_w  = r_mw.result_src;
  assign mdu_stall     = w_mdu_stall;
  assign ill_cnt       = r_ill_cnt;

endmodule

// File: tb/tb_riscv_ctrl_pipeline.sv
// Directed bench for riscv_ctrl_pipeline with hand-computed expectations.
// Define RISCV_CTRL_MEXT_EN to also run the MDU stall sequences.
module tb_riscv_ctrl_pipeline;

  localparam logic [31:0] I_NOP   = 32'h0000_0013;
  localparam logic [31:0] I_AUIPC = 32'h0000_1297;
  localparam logic [31:0] I_LW    = 32'h0000_A283;
  localparam logic [31:0] I_SW    = 32'h0050_A023;
  localparam logic [31:0] I_BLT   = 32'h0020_C063;
  localparam logic [31:0] I_BBAD  = 32'h0020_A063;
  localparam logic [31:0] I_ADD   = 32'h0020_81B3;
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;
  localparam logic [31:0] I_RBAD  = 32'h2020_81B3;
  localparam logic [31:0] I_MUL   = 32'h0220_81B3;
  localparam logic [31:0] I_JAL   = 32'h0000_00EF;
  localparam logic [31:0] I_JALR  = 32'h0000_80E7;
  localparam logic [31:0] I_LUI   = 32'h0000_12B7;
  localparam logic [31:0] I_ZERO  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d;
  logic        stall_d;
  logic        flush_e;
  logic [2:0]  imm_src_d;
  logic        illegal_d;
  logic        reg_write_e, reg_write_m, reg_write_w;
  logic [2:0]  result_src_e, result_src_m, result_src_w;
  logic        mem_write_e, mem_write_m;
  logic        jump_e, branch_e, jalr_src_e;
  logic [2:0]  branch_type_e;
  logic [1:0]  alu_op_e;
  logic        alu_src_e;
  logic        mdu_stall;
  logic [7:0]  ill_cnt;

  int n_total;
  int n_bad;
  int exp_ill;

  riscv_ctrl_pipeline #(.MDU_LATENCY(4), .ILL_CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_d       (instr_d),
    .stall_d       (stall_d),
    .flush_e       (flush_e),
    .imm_src_d     (imm_src_d),
    .illegal_d     (illegal_d),
    .reg_write_e   (reg_write_e),
    .reg_write_m   (reg_write_m),
    .reg_write_w   (reg_write_w),
    .result_src_e  (result_src_e),
    .result_src_m  (result_src_m),
    .result_src_w  (result_src_w),
    .mem_write_e   (mem_write_e),
    .mem_write_m   (mem_write_m),
    .jump_e        (jump_e),
    .branch_e      (branch_e),
    .jalr_src_e    (jalr_src_e),
    .branch_type_e (branch_type_e),
    .alu_op_e      (alu_op_e),
    .alu_src_e     (alu_src_e),
    .mdu_stall     (mdu_stall),
    .ill_cnt       (ill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp_ill = 0;
    rst_n   = 1'b0;
    instr_d = I_NOP;
    stall_d = 1'b0;
    flush_e = 1'b0;
    #3;
    chk("rst_rw_e", 32'(reg_write_e), 32'd0);
    chk("rst_rw_w", 32'(reg_write_w), 32'd0);
    chk("rst_ill", 32'(ill_cnt), 32'd0);
    chk("rst_stall", 32'(mdu_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // AUIPC through e, m, w
    instr_d = I_AUIPC;
    #1;
    chk("auipc_imm", 32'(imm_src_d), 32'd3);
    tick();
    instr_d = I_NOP;
    chk("auipc_res_e", 32'(result_src_e), 32'd4);
    chk("auipc_rw_e", 32'(reg_write_e), 32'd1);
    tick();
    chk("auipc_res_m", 32'(result_src_m), 32'd4);
    tick();
    chk("auipc_res_w", 32'(result_src_w), 32'd4);
    chk("auipc_rw_w", 32'(reg_write_w), 32'd1);

    // branches
    instr_d = I_BLT;
    #1;
    chk("blt_imm", 32'(imm_src_d), 32'd2);
    chk("blt_ill_d", 32'(illegal_d), 32'd0);
    tick();
    chk("blt_br_e", 32'(branch_e), 32'd1);
    chk("blt_type_e", 32'(branch_type_e), 32'd4);
    chk("blt_alu_e", 32'(alu_op_e), 32'd1);
    chk("blt_rw_e", 32'(reg_write_e), 32'd0);
    instr_d = I_BBAD;
    #1;
    chk("bbad_ill_d", 32'(illegal_d), 32'd1);
    tick();
    exp_ill++;
    chk("bbad_br_e", 32'(branch_e), 32'd0);
    chk("bbad_type_e", 32'(branch_type_e), 32'd0);
    chk("bbad_cnt", 32'(ill_cnt), 32'(exp_ill));

    // stores: normal, flush+stall, stall alone
    instr_d = I_SW;
    #1;
    chk("sw_imm", 32'(imm_src_d), 32'd1);
    tick();
    chk("sw_mw_e", 32'(mem_write_e), 32'd1);
    chk("sw_alusrc_e", 32'(alu_src_e), 32'd1);
    tick();
    chk("sw_mw_m", 32'(mem_write_m), 32'd1);
    stall_d = 1'b1;
    flush_e = 1'b1;
    tick();
    chk("swfl_mw_e", 32'(mem_write_e), 32'd0);
    flush_e = 1'b0;
    tick();
    chk("swst_mw_e", 32'(mem_write_e), 32'd0);
    instr_d = I_BBAD;
    tick();
    chk("stall_ill_cnt", 32'(ill_cnt), 32'(exp_ill));
    stall_d = 1'b0;

    // R-type and jumps
    instr_d = I_ADD;
    tick();
    chk("add_alu_e", 32'(alu_op_e), 32'd2);
    chk("add_alusrc_e", 32'(alu_src_e), 32'd0);
    instr_d = I_SUB;
    tick();
    chk("sub_alu_e", 32'(alu_op_e), 32'd2);
    instr_d = I_RBAD;
    tick();
    exp_ill++;
    chk("rbad_rw_e", 32'(reg_write_e), 32'd0);
    chk("rbad_cnt", 32'(ill_cnt), 32'(exp_ill));
    instr_d = I_JAL;
    #1;
    chk("jal_imm", 32'(imm_src_d), 32'd4);
    tick();
    chk("jal_jump_e", 32'(jump_e), 32'd1);
    chk("jal_res_e", 32'(result_src_e), 32'd2);
    chk("jal_jalr_e", 32'(jalr_src_e), 32'd0);
    instr_d = I_JALR;
    tick();
    chk("jalr_jalr_e", 32'(jalr_src_e), 32'd1);
    chk("jalr_alusrc", 32'(alu_src_e), 32'd1);
    instr_d = I_LUI;
    tick();
    chk("lui_res_e", 32'(result_src_e), 32'd3);

`ifndef RISCV_CTRL_MEXT_EN
    instr_d = I_MUL;
    #1;
    chk("mul_ill_d", 32'(illegal_d), 32'd1);
    tick();
    exp_ill++;
    chk("mul_cnt", 32'(ill_cnt), 32'(exp_ill));
    chk("mul_nostall", 32'(mdu_stall), 32'd0);
`else
    instr_d = I_MUL;
    tick();
    instr_d = I_NOP;
    chk("mul_alu_e", 32'(alu_op_e), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("mul_stall_hi", 32'(mdu_stall), 32'd1);
      tick();
      chk("mul_bubble_m", 32'(reg_write_m), 32'd0);
    end
    chk("mul_stall_lo", 32'(mdu_stall), 32'd0);
    chk("mul_held_e", 32'(alu_op_e), 32'd3);
    tick();
    chk("mul_in_m", 32'(reg_write_m), 32'd1);
    chk("mul_next_e", 32'(alu_op_e), 32'd2);

    instr_d = I_MUL;
    tick();
    instr_d = I_NOP;
    tick();
    chk("mulfl_stall", 32'(mdu_stall), 32'd1);
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    chk("mulfl_idle", 32'(mdu_stall), 32'd0);
    chk("mulfl_alu_e", 32'(alu_op_e), 32'd0);
    chk("mulfl_m0", 32'(reg_write_m), 32'd0);
    tick();
    chk("mulfl_m1", 32'(reg_write_m), 32'd0);
    chk("mulfl_nop_e", 32'(alu_op_e), 32'd2);
`endif

    // asynchronous reset with LW in m
    instr_d = I_LW;
    tick();
    instr_d = I_NOP;
    tick();
    chk("lw_res_m", 32'(result_src_m), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rw_e", 32'(reg_write_e), 32'd0);
    chk("arst_res_m", 32'(result_src_m), 32'd0);
    chk("arst_rw_m", 32'(reg_write_m), 32'd0);
    chk("arst_res_w", 32'(result_src_w), 32'd0);
    chk("arst_ill", 32'(ill_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation of the illegal counter
    instr_d = I_ZERO;
    for (int i = 0; i < 255; i++) tick();
    chk("sat_255", 32'(ill_cnt), 32'd255);
    tick();
    chk("sat_hold", 32'(ill_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
